// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer geometry and Gray/binary helpers.
// The helpers operate on a wide vector so any narrower pointer can use them after
// zero-extension; leading zeros do not disturb either conversion.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_W = 4;
  localparam int unsigned PTR_MAX_W   = 16;

  typedef logic [FIFO_ADDR_W:0] ptr_t;
  typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

  // b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]
  function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
    ptr_wide_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/wlevel_tracker_if.sv
// Producer-side status bundle of the write-level tracker.
// master: the write-pointer handler / producer; slave: the tracker itself.
interface wlevel_tracker_if #(
  parameter int unsigned ADDR_W = fifo_pkg::FIFO_ADDR_W
);

  logic [ADDR_W:0] g_rptr;
  logic [ADDR_W:0] wbin;
  logic            w_en;
  logic            full;
  logic            err_clr;
  logic [ADDR_W:0] rbin_sync;
  logic [ADDR_W:0] wlevel;
  logic [ADDR_W:0] wfree;
  logic            almost_full;
  logic            ovf_err;
  logic            level_err;
  logic [7:0]      drop_cnt;

  modport master (
    output g_rptr, wbin, w_en, full, err_clr,
    input  rbin_sync, wlevel, wfree, almost_full, ovf_err, level_err, drop_cnt
  );

  modport slave (
    input  g_rptr, wbin, w_en, full, err_clr,
    output rbin_sync, wlevel, wfree, almost_full, ovf_err, level_err, drop_cnt
  );

endinterface

// File: rtl/sync_ff.sv
// Generic multi-flop synchroniser with asynchronous active-low reset.
// Only Gray-coded or otherwise single-bit-changing buses may pass through it.
module sync_ff #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the sampled value down the chain one stage per edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/wlevel_tracker.sv
// Write-domain status decoder for the async FIFO: brings the Gray read pointer into
// wclk, decodes it, and derives fill level, free space, almost-full and error flags.
// Pure observer: it never stalls the write-pointer handler.
module wlevel_tracker
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W      = FIFO_ADDR_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_THRESH   = 12
) (
  input logic            wclk,
  input logic            wrst_n,
  wlevel_tracker_if.slave bus
);

  localparam int unsigned PTR_W    = ADDR_W + 1;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  // Errors stay masked until the synchroniser, decode and level registers hold real data.
  localparam int unsigned SETTLE   = SYNC_STAGES + 2;
  localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);

  typedef logic [ADDR_W:0] lptr_t;

  localparam lptr_t                DEPTH_P  = lptr_t'(DEPTH);
  localparam lptr_t                AF_P     = lptr_t'(AF_THRESH);
  localparam logic [SETTLE_W-1:0]  SETTLE_P = SETTLE_W'(SETTLE);
  localparam logic [7:0]           DROP_MAX = 8'hFF;

  lptr_t               g_sync;
  ptr_wide_t           g_wide;
  ptr_wide_t           b_wide;
  lptr_t               rbin_d;
  lptr_t               rbin_sync_q;
  lptr_t               diff;
  logic                over;
  lptr_t               level_d;
  lptr_t               wlevel_q;
  lptr_t               wfree_q;
  logic                af_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                settled;
  logic                lerr_set;
  logic                drop;
  logic                ovf_d, ovf_q;
  logic                lerr_d, lerr_q;
  logic [7:0]          drop_d, drop_q;
  logic                unused_b_hi;

  sync_ff #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk_i  (wclk),
    .rst_ni (wrst_n),
    .d_i    (bus.g_rptr),
    .q_o    (g_sync)
  );

  assign g_wide      = PTR_MAX_W'(g_sync);
  assign b_wide      = gray2bin(g_wide);
  assign rbin_d      = b_wide[ADDR_W:0];
  assign unused_b_hi = ^b_wide[PTR_MAX_W-1:PTR_W];

  // Register the decoded read pointer so level arithmetic sees a clean binary value.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rbin_sync_q <= '0;
    end else begin
      rbin_sync_q <= rbin_d;
    end
  end

  // Modulo pointer difference; anything above DEPTH means the reader passed the writer.
  always_comb begin
    diff    = bus.wbin - rbin_sync_q;
    over    = (diff > DEPTH_P);
    level_d = over ? DEPTH_P : diff;
  end

  // Level, free space and almost-full all come from the same diff to stay aligned.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_q <= '0;
      wfree_q  <= DEPTH_P;
      af_q     <= 1'b0;
    end else begin
      wlevel_q <= level_d;
      wfree_q  <= DEPTH_P - level_d;
      af_q     <= (level_d >= AF_P);
    end
  end

  // Count edges since reset release, saturating once the pipeline holds valid data.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      settle_q <= '0;
    end else if (settle_q != SETTLE_P) begin
      settle_q <= settle_q + 1'b1;
    end
  end

  assign settled  = (settle_q == SETTLE_P);
  assign lerr_set = settled & over;
  assign drop     = settled & bus.w_en & bus.full;

  // Sticky flags and drop counter; a same-edge set beats err_clr.
  always_comb begin
    ovf_d  = ovf_q | drop;
    lerr_d = lerr_q | lerr_set;
    drop_d = drop_q;
    if (drop && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 8'd1;
    end
    if (bus.err_clr) begin
      ovf_d  = drop;
      lerr_d = lerr_set;
      drop_d = {7'd0, drop};
    end
  end

  // Error state registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      ovf_q  <= 1'b0;
      lerr_q <= 1'b0;
      drop_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      lerr_q <= lerr_d;
      drop_q <= drop_d;
    end
  end

  assign bus.rbin_sync   = rbin_sync_q;
  assign bus.wlevel      = wlevel_q;
  assign bus.wfree       = wfree_q;
  assign bus.almost_full = af_q;
  assign bus.ovf_err     = ovf_q;
  assign bus.level_err   = lerr_q;
  assign bus.drop_cnt    = drop_q;

endmodule
